// File: rtl/hex_msg_pkg.sv
// Shared constants for the hex message scroller.
//   - character codes understood by the 7-segment decoder
//   - active-low gfedcba segment patterns for those codes
//   - operating mode encodings driven on the scroller's mode input
package hex_msg_pkg;

  // Character codes (low two bits of a character; wider codes with any
  // upper bit set are shown as blank).
  localparam logic [1:0] CH_D     = 2'd0;
  localparam logic [1:0] CH_E     = 2'd1;
  localparam logic [1:0] CH_1     = 2'd2;
  localparam logic [1:0] CH_BLANK = 2'd3;

  // Segment patterns, active low, bit order gfedcba.
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    MODE_MAN  = 2'b00,  // offset follows man_sel
    MODE_UP   = 2'b01,  // offset +1 per tick
    MODE_DN   = 2'b10,  // offset -1 per tick
    MODE_HOLD = 2'b11   // everything frozen
  } mode_e;

endpackage

// File: rtl/seg7_char_decoder.sv
// Combinational character-code to 7-segment decoder.
// Ports:
//   code  in  CHAR_W  character code (0 'd', 1 'E', 2 '1', 3 blank)
//   seg   out 7       active-low gfedcba segment pattern
// Any code with a bit set above bit 1 decodes to blank. CHAR_W must be >= 2.
module seg7_char_decoder
  import hex_msg_pkg::*;
#(
  parameter int CHAR_W = 2
) (
  input  logic [CHAR_W-1:0] code,
  output logic [6:0]        seg
);

  logic upper_set;

  generate
    if (CHAR_W > 2) begin : g_wide
      assign upper_set = |code[CHAR_W-1:2];
    end else begin : g_narrow
      assign upper_set = 1'b0;
    end
  endgenerate

  always_comb begin
    seg = SEG_OFF;
    if (!upper_set) begin
      case (code[1:0])
        CH_D:     seg = SEG_D;
        CH_E:     seg = SEG_E;
        CH_1:     seg = SEG_1;
        default:  seg = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/hex_msg_scroller.sv
// Message scroller for N_DISP seven-segment displays.
// Holds an N_CHARS message and shows a window into it starting at 'offset';
// the window either follows a switch value, scrolls up/down on a prescaled
// tick, or holds.
// Ports:
//   CLOCK_50  in   1               system clock
//   resetn    in   1               synchronous reset, active low
//   msg_in    in   N_CHARS*CHAR_W  message; char k = msg_in[k*CHAR_W +: CHAR_W]
//   load      in   1               single-cycle pulse: capture msg_in
//   mode      in   2               00 manual, 01 auto-up, 10 auto-down, 11 hold
//   man_sel   in   OFS_W           offset used in manual mode
//   HEX       out  N_DISP*7        display i = HEX[i*7 +: 7], active low gfedcba
//   offset    out  OFS_W           current window offset
//   tick      out  1               single-cycle pulse when the prescaler expires
// Handshake: there is no valid/ready pair. load is a plain strobe sampled on
// every rising edge; each cycle it is high the message is recaptured. No
// back-pressure exists, the block accepts a load in every cycle.
// Timing: HEX is registered from msg_buf_q/offset_q, so a change in either
// reaches HEX one edge after it is registered.
module hex_msg_scroller
  import hex_msg_pkg::*;
#(
  parameter  int CHAR_W      = 2,
  parameter  int N_CHARS     = 4,
  parameter  int N_DISP      = 4,
  parameter  int TICK_CYCLES = 50_000_000,
  localparam int OFS_W       = (N_CHARS > 2) ? $clog2(N_CHARS) : 1,
  localparam int PS_W        = $clog2(TICK_CYCLES)
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic [N_CHARS*CHAR_W-1:0]   msg_in,
  input  logic                        load,
  input  logic [1:0]                  mode,
  input  logic [OFS_W-1:0]            man_sel,
  output logic [N_DISP*7-1:0]         HEX,
  output logic [OFS_W-1:0]            offset,
  output logic                        tick
);

  localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(N_CHARS - 1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_CYCLES - 1);

  // State
  logic [N_CHARS-1:0][CHAR_W-1:0] msg_buf_q, msg_buf_d;
  logic [OFS_W-1:0]               offset_q,  offset_d;
  logic [PS_W-1:0]                ps_q,      ps_d;
  logic                           tick_q,    tick_d;
  mode_e                          mode_q,    mode_d;
  logic [N_DISP*7-1:0]            hex_q,     hex_d;

  mode_e mode_in;
  logic  mode_chg;
  logic  counting;
  logic  ps_wrap;
  logic  sel_ok;

  assign mode_in  = mode_e'(mode);
  // mode_q is the mode seen on the previous edge; any difference restarts
  // the prescaler so a new scroll direction always starts a full period.
  assign mode_chg = (mode_in != mode_q);
  assign counting = (mode_in == MODE_UP) || (mode_in == MODE_DN);
  assign ps_wrap  = counting && !mode_chg && (ps_q == PS_LAST);

  // man_sel can only exceed the message when N_CHARS is not a power of two.
  generate
    if ((1 << OFS_W) == N_CHARS) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_part
      assign sel_ok = ({1'b0, man_sel} < (OFS_W+1)'(N_CHARS));
    end
  endgenerate

  always_comb begin
    msg_buf_d = msg_buf_q;
    offset_d  = offset_q;
    ps_d      = ps_q;
    tick_d    = 1'b0;
    mode_d    = mode_in;

    if (load) begin
      // load wins over a pending tick and over the manual select.
      msg_buf_d = msg_in;
      offset_d  = '0;
      ps_d      = '0;
    end else begin
      if (mode_chg) begin
        ps_d = '0;
      end else if (counting) begin
        ps_d = ps_wrap ? '0 : ps_q + PS_W'(1);
      end
      tick_d = ps_wrap;

      case (mode_in)
        MODE_MAN: begin
          if (sel_ok) offset_d = man_sel;
        end
        MODE_UP: begin
          if (ps_wrap) offset_d = (offset_q == OFS_LAST) ? '0 : offset_q + OFS_W'(1);
        end
        MODE_DN: begin
          if (ps_wrap) offset_d = (offset_q == '0) ? OFS_LAST : offset_q - OFS_W'(1);
        end
        default: begin
          // hold: nothing moves
        end
      endcase
    end
  end

  // Display i shows character (i + offset) mod N_CHARS. i mod N_CHARS is an
  // elaboration constant, so the remaining sum is below 2*N_CHARS and one
  // compare-and-subtract finishes the wrap.
  generate
    for (genvar i = 0; i < N_DISP; i++) begin : g_disp
      localparam int BASE = i % N_CHARS;
      logic [OFS_W:0] sum;
      logic [OFS_W:0] idx;

      always_comb begin
        sum = {1'b0, offset_q} + (OFS_W+1)'(BASE);
        idx = sum;
        if (sum >= (OFS_W+1)'(N_CHARS)) idx = sum - (OFS_W+1)'(N_CHARS);
      end

      seg7_char_decoder #(.CHAR_W(CHAR_W)) u_dec (
        .code (msg_buf_q[idx[OFS_W-1:0]]),
        .seg  (hex_d[i*7 +: 7])
      );
    end
  endgenerate

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      msg_buf_q <= {N_CHARS{CHAR_W'(CH_BLANK)}};
      offset_q  <= '0;
      ps_q      <= '0;
      tick_q    <= 1'b0;
      mode_q    <= MODE_MAN;
      hex_q     <= '1;
    end else begin
      msg_buf_q <= msg_buf_d;
      offset_q  <= offset_d;
      ps_q      <= ps_d;
      tick_q    <= tick_d;
      mode_q    <= mode_d;
      hex_q     <= hex_d;
    end
  end

  assign HEX    = hex_q;
  assign offset = offset_q;
  assign tick   = tick_q;

endmodule
